// File: rtl/rca_pipe_pkg.sv
// Shared constants, chunk-width helper and per-beat control struct for rca_pipe_adder.
// Each beat's operand remainders and partial sum travel next to this struct as WIDTH-bit vectors.
package rca_pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // Chunk width; a zero stage count is reported by the top-level legality check.
  function automatic int unsigned calc_cw(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } beat_ctrl_t;

endpackage

// File: rtl/rca_pipe_stage.sv
// One CW-bit ripple-carry slice (chunk IDX) followed by its pipeline register.
// The slice carry goes into the register; the operands pass through unchanged as skew data.
module rca_pipe_stage
  import rca_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CW    = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  beat_ctrl_t       i_ctrl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  output beat_ctrl_t       o_ctrl,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_sum
);

  localparam int unsigned LSB = IDX * CW;

  logic [CW-1:0]    w_a;
  logic [CW-1:0]    w_b;
  logic [CW-1:0]    w_s;
  logic [CW:0]      w_c;
  logic [WIDTH-1:0] w_sum_next;
  beat_ctrl_t       w_ctrl_next;

  beat_ctrl_t       r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;

  assign w_a    = i_a[LSB +: CW];
  assign w_b    = i_b[LSB +: CW] ^ {CW{i_ctrl.sub}};
  assign w_c[0] = i_ctrl.carry;

  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_fa
      assign w_s[gi]     = w_a[gi] ^ w_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (w_a[gi] & w_b[gi]) | (w_c[gi] & (w_a[gi] ^ w_b[gi]));
    end
  endgenerate

  // This chunk of the incoming partial sum is still zero, so OR merges it in.
  always_comb begin
    w_sum_next        = i_sum | (WIDTH'(w_s) << LSB);
    w_ctrl_next       = i_ctrl;
    w_ctrl_next.carry = w_c[CW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
    end else if (i_adv) begin
      r_ctrl <= w_ctrl_next;
      r_a    <= i_a;
      r_b    <= i_b;
      r_sum  <= w_sum_next;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_sum  = r_sum;

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides and a single global advance.
// Define RCA_PIPE_OVF_EN to add the out_ovf signed-overflow output.
module rca_pipe_adder
  import rca_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CW = calc_cw(WIDTH, STAGES);

  if ((STAGES == 0) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("rca_pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  beat_ctrl_t       w_ctrl [STAGES+1];
  logic [WIDTH-1:0] w_a    [STAGES+1];
  logic [WIDTH-1:0] w_b    [STAGES+1];
  logic [WIDTH-1:0] w_sum  [STAGES+1];
  logic             w_adv;

  // The whole pipe moves together; a held output freezes every stage.
  assign w_adv    = !w_ctrl[STAGES].valid || out_ready;
  assign in_ready = w_adv;

  assign w_ctrl[0] = '{valid: in_valid, sub: in_sub, carry: in_sub | in_cin};
  assign w_a[0]    = in_a;
  assign w_b[0]    = in_b;
  assign w_sum[0]  = '0;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      rca_pipe_stage #(
        .WIDTH (WIDTH),
        .CW    (CW),
        .IDX   (gi)
      ) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (w_adv),
        .i_ctrl (w_ctrl[gi]),
        .i_a    (w_a[gi]),
        .i_b    (w_b[gi]),
        .i_sum  (w_sum[gi]),
        .o_ctrl (w_ctrl[gi+1]),
        .o_a    (w_a[gi+1]),
        .o_b    (w_b[gi+1]),
        .o_sum  (w_sum[gi+1])
      );
    end
  endgenerate

  assign out_valid = w_ctrl[STAGES].valid;
  assign out_sum   = w_sum[STAGES];
  assign out_cout  = w_ctrl[STAGES].carry;

`ifdef RCA_PIPE_OVF_EN
  logic w_a_msb;
  logic w_b_msb;
  logic w_s_msb;

  // Operand sign bits ride along in the final skew register, so the check lines up with out_sum.
  assign w_a_msb = w_a[STAGES][WIDTH-1];
  assign w_b_msb = w_b[STAGES][WIDTH-1] ^ w_ctrl[STAGES].sub;
  assign w_s_msb = w_sum[STAGES][WIDTH-1];
  assign out_ovf = (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
`endif

  logic w_unused;
  assign w_unused = ^{w_a[STAGES], w_b[STAGES], w_ctrl[STAGES].sub};

endmodule
